// File: rtl/arm_ctrl_pkg.sv
// Shared types for the ARM pipelined controller: condition codes,
// data-processing commands, ALU encodings and the stage control bundle.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000, COND_NE = 4'b0001,
        COND_CS = 4'b0010, COND_CC = 4'b0011,
        COND_MI = 4'b0100, COND_PL = 4'b0101,
        COND_VS = 4'b0110, COND_VC = 4'b0111,
        COND_HI = 4'b1000, COND_LS = 4'b1001,
        COND_GE = 4'b1010, COND_LT = 4'b1011,
        COND_GT = 4'b1100, COND_LE = 4'b1101,
        COND_AL = 4'b1110, COND_NV = 4'b1111
    } cond_e;

    typedef enum logic [3:0] {
        CMD_AND = 4'b0000,
        CMD_EOR = 4'b0001,
        CMD_SUB = 4'b0010,
        CMD_ADD = 4'b0100,
        CMD_TST = 4'b1000,
        CMD_CMP = 4'b1010,
        CMD_ORR = 4'b1100
    } dp_cmd_e;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;

    // All-zero value of this bundle is a NOP.
    typedef struct packed {
        cond_e      cond;
        logic       reg_w;
        logic       mem_w;
        logic       mem_to_reg;
        logic       alu_src;
        logic       branch;
        logic       pcs;
        logic       no_write;
        logic [1:0] flag_w;
        logic [2:0] alu;
    } ctrl_t;

endpackage

// File: rtl/arm_pipelined_control_pipeline_if.sv
// Decode-side inputs and stage-qualified control outputs of the
// ARM pipelined controller.
interface arm_pipelined_control_pipeline_if #(
    parameter int ALU_CTRL_W = 2
);
    logic [3:0]            i_Cond_D;
    logic [1:0]            i_Op_D;
    logic [5:0]            i_Funct_D;
    logic [3:0]            i_Rd_D;
    logic [3:0]            i_ALU_Flags_E;
    logic                  i_Flush_E;
    logic [1:0]            o_Reg_Src_D;
    logic [1:0]            o_Imm_Src_D;
    logic [ALU_CTRL_W-1:0] o_ALU_Control_E;
    logic                  o_ALU_Src_E;
    logic                  o_Branch_Taken_E;
    logic                  o_Mem_Write_M;
    logic                  o_Reg_Write_M;
    logic                  o_Mem_To_Reg_E;
    logic                  o_Reg_Write_W;
    logic                  o_Mem_To_Reg_W;
    logic                  o_PC_Src_W;
    logic                  o_PC_Wr_Pending_F;
    logic [3:0]            o_Flags;

    modport master (
        output i_Cond_D, i_Op_D, i_Funct_D, i_Rd_D,
        output i_ALU_Flags_E, i_Flush_E,
        input  o_Reg_Src_D, o_Imm_Src_D, o_ALU_Control_E,
        input  o_ALU_Src_E, o_Branch_Taken_E, o_Mem_Write_M,
        input  o_Reg_Write_M, o_Mem_To_Reg_E, o_Reg_Write_W,
        input  o_Mem_To_Reg_W, o_PC_Src_W, o_PC_Wr_Pending_F,
        input  o_Flags
    );

    modport slave (
        input  i_Cond_D, i_Op_D, i_Funct_D, i_Rd_D,
        input  i_ALU_Flags_E, i_Flush_E,
        output o_Reg_Src_D, o_Imm_Src_D, o_ALU_Control_E,
        output o_ALU_Src_E, o_Branch_Taken_E, o_Mem_Write_M,
        output o_Reg_Write_M, o_Mem_To_Reg_E, o_Reg_Write_W,
        output o_Mem_To_Reg_W, o_PC_Src_W, o_PC_Wr_Pending_F,
        output o_Flags
    );
endinterface

// File: rtl/arm_cond_unit.sv
// Combinational ARM condition check of a 4-bit cond field against NZCV.
// Encoding 1111 never executes.
module arm_cond_unit
    import arm_ctrl_pkg::*;
(
    input  cond_e      cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);
    logic n, z, c, v, ge;

    assign {n, z, c, v} = flags;
    assign ge = (n == v);

    always_comb begin
        cond_ex = 1'b0;
        unique case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = ge;
            COND_LT: cond_ex = ~ge;
            COND_GT: cond_ex = ~z & ge;
            COND_LE: cond_ex = z | ~ge;
            COND_AL: cond_ex = 1'b1;
            COND_NV: cond_ex = 1'b0;
        endcase
    end
endmodule

// File: rtl/arm_pipelined_control_pipeline.sv
// ARM pipelined controller: decoder, conditional execution and the
// D->E->M->W control registers plus the architectural NZCV register.
module arm_pipelined_control_pipeline
    import arm_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 2,
    parameter bit EXT_ALU    = 1'b0
) (
    input logic i_CLK,
    input logic i_RST,
    arm_pipelined_control_pipeline_if.slave bus
);
    ctrl_t      dec, de, gated, em, mw;
    logic [1:0] reg_src, imm_src;
    logic [3:0] flags;
    logic       cond_ex;
    logic       dp_ok, arith, s_bit;

    assign s_bit = bus.i_Funct_D[0];

    always_comb begin
        dec     = '0;
        reg_src = '0;
        imm_src = '0;
        dp_ok   = 1'b0;
        arith   = 1'b0;
        if (!i_RST) begin
            unique case (1'b1)
                (bus.i_Op_D == OP_DP): begin
                    dp_ok = 1'b1;
                    unique case (dp_cmd_e'(bus.i_Funct_D[4:1]))
                        CMD_ADD: begin dec.alu = ALU_ADD; arith = 1'b1; end
                        CMD_SUB: begin dec.alu = ALU_SUB; arith = 1'b1; end
                        CMD_AND: dec.alu = ALU_AND;
                        CMD_ORR: dec.alu = ALU_ORR;
                        CMD_CMP: begin
                            dec.alu      = ALU_SUB;
                            arith        = 1'b1;
                            dec.no_write = 1'b1;
                        end
                        CMD_EOR: begin
                            if (EXT_ALU) dec.alu = ALU_EOR;
                            else         dp_ok   = 1'b0;
                        end
                        CMD_TST: begin
                            if (EXT_ALU) begin
                                dec.alu      = ALU_AND;
                                dec.no_write = 1'b1;
                            end else begin
                                dp_ok = 1'b0;
                            end
                        end
                        default: dp_ok = 1'b0;
                    endcase
                    if (dp_ok) begin
                        dec.reg_w   = 1'b1;
                        dec.alu_src = bus.i_Funct_D[5];
                        dec.flag_w  = {s_bit, s_bit & arith};
                    end else begin
                        dec = '0;
                    end
                end
                (bus.i_Op_D == OP_MEM): begin
                    dec.alu_src = 1'b1;
                    dec.alu     = ALU_ADD;
                    imm_src     = 2'b01;
                    if (bus.i_Funct_D[0]) begin
                        dec.reg_w      = 1'b1;
                        dec.mem_to_reg = 1'b1;
                    end else begin
                        dec.mem_w = 1'b1;
                        reg_src   = 2'b10;
                    end
                end
                (bus.i_Op_D == OP_BR): begin
                    dec.branch  = 1'b1;
                    dec.alu_src = 1'b1;
                    imm_src     = 2'b10;
                    reg_src     = 2'b01;
                end
                default: ;
            endcase
            dec.cond = cond_e'(bus.i_Cond_D);
            dec.pcs  = ((bus.i_Rd_D == 4'd15) & dec.reg_w) | dec.branch;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST || bus.i_Flush_E) de <= '0;
        else                        de <= dec;
    end

    arm_cond_unit u_cond (
        .cond    (de.cond),
        .flags   (flags),
        .cond_ex (cond_ex)
    );

    // Failed-condition instructions travel on as harmless bubbles.
    always_comb begin
        gated        = de;
        gated.reg_w  = de.reg_w & cond_ex & ~de.no_write;
        gated.mem_w  = de.mem_w & cond_ex;
        gated.pcs    = de.pcs & cond_ex & ~de.no_write;
        gated.branch = de.branch & cond_ex;
        gated.flag_w = de.flag_w & {2{cond_ex}};
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            em    <= '0;
            mw    <= '0;
            flags <= '0;
        end else begin
            em <= gated;
            mw <= em;
            if (gated.flag_w[1]) flags[3:2] <= bus.i_ALU_Flags_E[3:2];
            if (gated.flag_w[0]) flags[1:0] <= bus.i_ALU_Flags_E[1:0];
        end
    end

    logic unused_mw;
    assign unused_mw = ^{mw.cond, mw.mem_w, mw.alu_src, mw.branch,
                         mw.no_write, mw.flag_w, mw.alu};

    assign bus.o_Reg_Src_D       = reg_src;
    assign bus.o_Imm_Src_D       = imm_src;
    assign bus.o_ALU_Control_E   = ALU_CTRL_W'(de.alu);
    assign bus.o_ALU_Src_E       = de.alu_src;
    assign bus.o_Branch_Taken_E  = gated.branch;
    assign bus.o_Mem_To_Reg_E    = de.mem_to_reg;
    assign bus.o_Mem_Write_M     = em.mem_w;
    assign bus.o_Reg_Write_M     = em.reg_w;
    assign bus.o_Reg_Write_W     = mw.reg_w;
    assign bus.o_Mem_To_Reg_W    = mw.mem_to_reg;
    assign bus.o_PC_Src_W        = mw.pcs;
    assign bus.o_PC_Wr_Pending_F = dec.pcs | de.pcs | em.pcs;
    assign bus.o_Flags           = flags;
endmodule

// File: tb/tb_arm_pipelined_control_pipeline.sv
// Scoreboard bench for the ARM pipelined controller: stimulus queues
// cycle-tagged expectations, a negedge monitor compares them.
module tb_arm_pipelined_control_pipeline;
    import arm_ctrl_pkg::*;

    localparam logic [31:0] NOP    = 32'hEC000000;
    localparam logic [31:0] ADDS   = 32'hE0900002;
    localparam logic [31:0] CMP    = 32'hE3500000;
    localparam logic [31:0] BEQ    = 32'h0A000000;
    localparam logic [31:0] STRNE  = 32'h15801000;
    localparam logic [31:0] STR    = 32'hE5801000;
    localparam logic [31:0] LDR    = 32'hE5901000;
    localparam logic [31:0] ADDPC  = 32'hE080F001;
    localparam logic [31:0] ADDNV  = 32'hF0801002;
    localparam logic [31:0] EOR    = 32'hE0201002;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] cond, rd, aflags;
    logic [1:0] op;
    logic [5:0] funct;
    logic       flush;

    always #5 clk = ~clk;

    arm_pipelined_control_pipeline_if #(.ALU_CTRL_W(2)) b0 ();
    arm_pipelined_control_pipeline_if #(.ALU_CTRL_W(3)) b1 ();

    assign b0.i_Cond_D      = cond;
    assign b0.i_Op_D        = op;
    assign b0.i_Funct_D     = funct;
    assign b0.i_Rd_D        = rd;
    assign b0.i_ALU_Flags_E = aflags;
    assign b0.i_Flush_E     = flush;
    assign b1.i_Cond_D      = cond;
    assign b1.i_Op_D        = op;
    assign b1.i_Funct_D     = funct;
    assign b1.i_Rd_D        = rd;
    assign b1.i_ALU_Flags_E = aflags;
    assign b1.i_Flush_E     = flush;

    arm_pipelined_control_pipeline #(.ALU_CTRL_W(2), .EXT_ALU(1'b0)) dut0 (
        .i_CLK (clk),
        .i_RST (rst),
        .bus   (b0.slave)
    );

    arm_pipelined_control_pipeline #(.ALU_CTRL_W(3), .EXT_ALU(1'b1)) dut1 (
        .i_CLK (clk),
        .i_RST (rst),
        .bus   (b1.slave)
    );

    typedef enum int {
        S_REGSRC, S_IMMSRC, S_ALUCTL, S_ALUSRC, S_BR, S_MEMW_M,
        S_REGW_M, S_M2R_E, S_REGW_W, S_M2R_W, S_PCSRC, S_PEND,
        S_FLAGS, S_XALU, S_XREGW, S_NUM
    } sig_e;

    typedef struct {
        int         cyc;
        sig_e       sig;
        logic [3:0] val;
        string      nm;
    } exp_t;

    exp_t       sb[$];
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    logic [3:0] got;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] probe(sig_e s);
        case (s)
            S_REGSRC: return {2'b0, b0.o_Reg_Src_D};
            S_IMMSRC: return {2'b0, b0.o_Imm_Src_D};
            S_ALUCTL: return {2'b0, b0.o_ALU_Control_E};
            S_ALUSRC: return {3'b0, b0.o_ALU_Src_E};
            S_BR:     return {3'b0, b0.o_Branch_Taken_E};
            S_MEMW_M: return {3'b0, b0.o_Mem_Write_M};
            S_REGW_M: return {3'b0, b0.o_Reg_Write_M};
            S_M2R_E:  return {3'b0, b0.o_Mem_To_Reg_E};
            S_REGW_W: return {3'b0, b0.o_Reg_Write_W};
            S_M2R_W:  return {3'b0, b0.o_Mem_To_Reg_W};
            S_PCSRC:  return {3'b0, b0.o_PC_Src_W};
            S_PEND:   return {3'b0, b0.o_PC_Wr_Pending_F};
            S_FLAGS:  return b0.o_Flags;
            S_XALU:   return {1'b0, b1.o_ALU_Control_E};
            S_XREGW:  return {3'b0, b1.o_Reg_Write_W};
            default:  return 4'hF;
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                checks++;
                got = probe(sb[i].sig);
                if (got !== sb[i].val) begin
                    failures++;
                    $display("FAIL %s cyc=%0d got=%h exp=%h",
                             sb[i].nm, cyc, got, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(logic [31:0] ins);
        cond  = ins[31:28];
        op    = ins[27:26];
        funct = ins[25:20];
        rd    = ins[15:12];
    endtask

    task automatic issue(logic [31:0] ins);
        tick();
        put(ins);
        flush = 1'b0;
    endtask

    task automatic issue_f(logic [31:0] ins, logic [3:0] fl);
        issue(ins);
        aflags = fl;
    endtask

    task automatic nops(int n);
        for (int i = 0; i < n; i++) issue(NOP);
    endtask

    task automatic exp(int d, sig_e s, logic [3:0] v, string n);
        sb.push_back('{cyc + d, s, v, n});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst    = 1'b1;
        cond   = 4'($urandom);
        op     = 2'($urandom);
        funct  = 6'($urandom);
        rd     = 4'($urandom);
        aflags = 4'($urandom);
        flush  = 1'($urandom);
        tick();
        for (int s = 0; s < S_NUM; s++) exp(0, sig_e'(s), 4'h0, "reset");
        cond   = 4'($urandom);
        op     = 2'($urandom);
        funct  = 6'($urandom);
        rd     = 4'($urandom);
        aflags = 4'($urandom);
        tick();
        rst    = 1'b0;
        aflags = 4'h0;
        put(NOP);
        flush  = 1'b0;
        nops(2);

        issue(ADDS);
        exp(0, S_PEND, 4'h0, "adds_pend");
        exp(1, S_ALUCTL, 4'h0, "adds_alu");
        exp(1, S_ALUSRC, 4'h0, "adds_alusrc");
        exp(2, S_FLAGS, 4'b0110, "adds_flags");
        exp(2, S_REGW_M, 4'h1, "adds_regw_m");
        exp(3, S_REGW_W, 4'h1, "adds_regw_w");
        issue_f(NOP, 4'b0110);
        nops(3);

        issue(CMP);
        exp(1, S_ALUCTL, 4'h1, "cmp_alu");
        exp(1, S_ALUSRC, 4'h1, "cmp_alusrc");
        exp(2, S_REGW_M, 4'h0, "cmp_nowrite");
        issue_f(NOP, 4'b0100);
        issue(BEQ);
        exp(0, S_FLAGS, 4'b0100, "cmp_flags");
        exp(0, S_IMMSRC, 4'b0010, "beq_immsrc");
        exp(0, S_REGSRC, 4'b0001, "beq_regsrc");
        exp(0, S_PEND, 4'h1, "beq_pend");
        exp(1, S_BR, 4'h1, "beq_taken");
        exp(3, S_PCSRC, 4'h1, "beq_pcsrc");
        nops(3);

        issue(CMP);
        issue_f(NOP, 4'b0000);
        issue(BEQ);
        exp(1, S_BR, 4'h0, "beq_not_taken");
        exp(3, S_PCSRC, 4'h0, "beq_not_pcsrc");
        nops(3);

        issue(CMP);
        issue_f(NOP, 4'b0100);
        issue(STRNE);
        exp(0, S_REGSRC, 4'b0010, "strne_regsrc");
        exp(2, S_MEMW_M, 4'h0, "strne_squash");
        nops(3);

        issue(STR);
        exp(1, S_ALUSRC, 4'h1, "str_alusrc");
        exp(2, S_MEMW_M, 4'h1, "str_memw");
        nops(3);

        issue(LDR);
        exp(1, S_M2R_E, 4'h1, "ldr_m2r_e");
        exp(3, S_M2R_W, 4'h1, "ldr_m2r_w");
        exp(3, S_REGW_W, 4'h1, "ldr_regw_w");
        nops(3);

        issue(ADDPC);
        flush = 1'b1;
        exp(0, S_PEND, 4'h1, "flush_pend_d");
        exp(1, S_PEND, 4'h0, "flush_pend_e");
        exp(3, S_REGW_W, 4'h0, "flush_regw_w");
        exp(3, S_PCSRC, 4'h0, "flush_pcsrc");
        nops(4);

        issue(ADDPC);
        exp(1, S_PEND, 4'h1, "addpc_pend_e");
        exp(2, S_PEND, 4'h1, "addpc_pend_m");
        exp(3, S_PEND, 4'h0, "addpc_pend_w");
        exp(3, S_PCSRC, 4'h1, "addpc_pcsrc");
        exp(3, S_REGW_W, 4'h1, "addpc_regw_w");
        nops(4);

        issue(ADDNV);
        exp(2, S_REGW_M, 4'h0, "nv_regw_m");
        nops(3);

        issue(EOR);
        exp(1, S_XALU, 4'b0100, "eor_ext_alu");
        exp(3, S_XREGW, 4'h1, "eor_ext_regw");
        exp(1, S_ALUCTL, 4'h0, "eor_base_alu");
        exp(3, S_REGW_W, 4'h0, "eor_base_regw");
        nops(3);

        issue(ADDS);
        issue_f(NOP, 4'b1001);
        rst = 1'b1;
        exp(1, S_REGW_M, 4'h0, "midrst_regw_m");
        exp(1, S_FLAGS, 4'h0, "midrst_flags");
        exp(2, S_REGW_W, 4'h0, "midrst_regw_w");
        issue(NOP);
        rst = 1'b0;
        nops(5);

        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain left=%0d", sb.size());
            failures += sb.size();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
